gpio_port_irq: RTL and testbench
================================

Name: gpio_port_irq

Overview:
- Parametrised Wishbone GPIO controller for up to 32 bidirectional pins.
- Provides per-pin direction, atomic set/clear output access, a synchronised pin-state readback and per-pin edge-triggered interrupts with a single combined IRQ output.
- Slave on the local Wishbone bus, classic single-cycle-ack protocol.

Parameters:
g_num_pins, 32, number of GPIO pins (1..32); register bits at and above g_num_pins read 0 and ignore writes
g_sync_stages, 3, input synchroniser depth (2..4)

Ports:
wb_clk_i  in  1  system clock
rst_n_i  in  1  reset, asynchronous assert, active-low
wb_addr_i  in  3  word address
wb_data_i  in  32  write data
wb_data_o  out  32  read data
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte lane selects
wb_ack_o  out  1  acknowledge
gpio_pins_b  inout  g_num_pins  GPIO pads
irq_o  out  1  interrupt request, active-high, level

Behaviour:
- Clock and reset: one clock (wb_clk_i); reset is asynchronous and active-low (rst_n_i). All state is cleared asynchronously on rst_n_i=0.
- Reset values:
  - PDR=0, DDR=0 (all pins inputs, pads Z), IMR=0, IPR=0, ISR=0.
  - Synchroniser and edge-history registers 0.
  - wb_ack_o=0, wb_data_o=0, irq_o=0.
- Register map (word address):
  - 0 SOPR (write-only): 1 bits set PDR bits.
  - 1 COPR (write-only): 1 bits clear PDR bits.
  - 2 PDR (R/W): output data.
  - 3 DDR (R/W): 1 = output.
  - 4 PSR (read-only): synchronised pad state.
  - 5 IMR (R/W): interrupt mask, 1 = enabled.
  - 6 IPR (R/W): edge select, 1 = rising, 0 = falling.
  - 7 ISR (R/W1C): pending flags.
  - Write-only registers read 0.
- Byte lanes: on writes, only lanes with wb_sel_i set are affected. For SOPR, COPR and ISR, bits in deselected lanes are treated as 0. Reads return all 32 bits.
- Handshake:
  - wb_ack_o <= cyc & stb & ~wb_ack_o, so ack is a one-cycle pulse in the cycle after the strobe is seen.
  - If stb is held, ack pulses every other cycle.
  - Writes take effect on the same edge that raises ack.
  - wb_data_o is registered on that edge and holds its value until the next read.
- Pad drive: gpio_pins_b[i] = DDR[i] ? PDR[i] : Z.
- Synchroniser:
  - Each pad passes through g_sync_stages flops. PSR is the last stage.
  - A pad change stable before edge k is visible in PSR after edge k+g_sync_stages-1.
  - Output pins read back their driven value through the same path.
- Edge detect:
  - prev <= PSR every cycle.
  - Event[i] = IPR[i] ? (PSR[i] & ~prev[i]) : (~PSR[i] & prev[i]).
  - On an event, ISR[i] is set on the next edge, independent of IMR.
  - ISR latches; repeated events do not toggle it.
- Simultaneous event and W1C of the same ISR bit in one cycle: set wins and the bit stays 1.
- Changing IPR or IMR has no effect on already-pending ISR bits.
- irq_o: registered, irq_o <= |(ISR & IMR). It rises one edge after ISR sets or IMR enables a pending bit, and falls one edge after the last enabled pending bit clears.
- Reset mid-transaction: ack drops immediately. The master must restart the cycle after reset release.
- Bits >= g_num_pins: PDR/DDR/IMR/IPR/ISR/PSR read 0 and never set; no pads exist for them.

Test Plan:
- Reset, read all 8 addresses -> all 0, irq_o=0, pads Z. Check ack latency = 1 cycle on each access.
- DDR=0xFFFF0000, SOPR=0xFF00FF00, COPR=0x55555555 -> pads[31:16]=0xAA00, pads[15:0]=Z, PDR reads 0xAA00AA00.
- DDR=0x0000FFFF, drive pads[31:16]=0xCAFE externally -> after g_sync_stages+1 cycles PSR reads 0xCAFExxxx, with low half = PDR[15:0].
- IPR=0x1 (pin0 rising), IMR=0x3, pin0 0->1 then pin1 1->0:
  - ISR=0x3, irq_o=1 exactly g_sync_stages+2 edges after the pin0 change.
  - W1C 0x1 -> ISR=0x2, irq_o stays 1.
  - W1C 0x2 -> irq_o=0 one edge later.
- Event on pin2 with IMR[2]=0 -> ISR[2]=1, irq_o=0. Then IMR=0x4 -> irq_o=1 one edge after the write ack.
- Byte-lane write PDR=0x12345678 with sel=0b0101 from PDR=0 -> PDR=0x00340078.
- g_num_pins=8 build: writing 0xFFFFFFFF to DDR reads back 0xFF.
- W1C collision: W1C of ISR[0] coincident with a new pin0 event -> ISR[0]=1.

Source files
------------

// File: rtl/gpio_port_irq.sv
// -----------------------------------------------------------------------------
// gpio_port_irq
//
// Wishbone-attached GPIO controller for up to 32 bidirectional pins. It
// provides per-pin direction, atomic set/clear of the output data, a
// synchronised pad-state readback and per-pin edge interrupts that are
// combined into one level IRQ output.
//
// Ports
//   wb_clk_i     system clock
//   rst_n_i      asynchronous, active-low reset
//   wb_addr_i    word address (8 registers)
//   wb_data_i    write data
//   wb_data_o    read data, registered, held until the next read
//   wb_cyc_i     bus cycle
//   wb_stb_i     strobe
//   wb_we_i      write enable
//   wb_sel_i     byte lane selects (writes only)
//   wb_ack_o     acknowledge, one-cycle pulse
//   gpio_pins_b  GPIO pads (g_num_pins wide)
//   irq_o        interrupt request, active-high level
//
// Register map (word address)
//   0 SOPR  W    1 bits set PDR bits
//   1 COPR  W    1 bits clear PDR bits
//   2 PDR   R/W  output data
//   3 DDR   R/W  direction, 1 = output
//   4 PSR   R    synchronised pad state
//   5 IMR   R/W  interrupt mask, 1 = enabled
//   6 IPR   R/W  edge select, 1 = rising, 0 = falling
//   7 ISR   R/W1C pending flags
//
// Handshake: a transfer is accepted in any cycle where wb_cyc_i & wb_stb_i
// are high and wb_ack_o is low. The register update (writes) and the read
// data capture (reads) happen on the same clock edge that raises wb_ack_o.
// wb_ack_o is high for exactly one cycle; a master that keeps wb_stb_i
// asserted therefore sees one acknowledge every other cycle.
// -----------------------------------------------------------------------------
module gpio_port_irq #(
  parameter int g_num_pins    = 32,
  parameter int g_sync_stages = 3
) (
  input  logic                  wb_clk_i,
  input  logic                  rst_n_i,
  input  logic [2:0]            wb_addr_i,
  input  logic [31:0]           wb_data_i,
  output logic [31:0]           wb_data_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  output logic                  wb_ack_o,
  inout  wire  [g_num_pins-1:0] gpio_pins_b,
  output logic                  irq_o
);

  localparam int N = g_num_pins;
  localparam int S = g_sync_stages;

  typedef enum logic [2:0] {
    A_SOPR = 3'd0,
    A_COPR = 3'd1,
    A_PDR  = 3'd2,
    A_DDR  = 3'd3,
    A_PSR  = 3'd4,
    A_IMR  = 3'd5,
    A_IPR  = 3'd6,
    A_ISR  = 3'd7
  } reg_addr_e;

  // Zero-extend an N-bit register image to the 32-bit bus.
  function automatic logic [31:0] zext(input logic [N-1:0] v);
    logic [31:0] r;
    r        = '0;
    r[N-1:0] = v;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [N-1:0]  pdr_q, pdr_d;
  logic [N-1:0]  ddr_q, ddr_d;
  logic [N-1:0]  imr_q, imr_d;
  logic [N-1:0]  ipr_q, ipr_d;
  logic [N-1:0]  isr_q, isr_d;
  logic [N-1:0]  prev_q;
  logic [N-1:0]  sync_q [S];
  logic          irq_q, irq_d;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic          access;
  logic          wr_en;
  logic          rd_en;
  reg_addr_e     addr;
  logic [31:0]   lane_mask;
  logic [N-1:0]  wkeep;    // bits of the register that this write may touch
  logic [N-1:0]  wbits;    // write data with deselected lanes forced to 0
  logic [N-1:0]  psr;
  logic [N-1:0]  edge_evt;

  assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en     = access & wb_we_i;
  assign rd_en     = access & ~wb_we_i;
  assign addr      = reg_addr_e'(wb_addr_i);
  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                      {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wkeep     = lane_mask[N-1:0];
  assign wbits     = wb_data_i[N-1:0] & wkeep;

  assign ack_d = wb_cyc_i & wb_stb_i & ~ack_q;

  // ---------------------------------------------------------------------------
  // Pad drive: each pad is driven only while its direction bit is set.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N; i++) begin : g_pad
    assign gpio_pins_b[i] = ddr_q[i] ? pdr_q[i] : 1'bz;
  end

  // ---------------------------------------------------------------------------
  // Input synchroniser. Output pins are sampled through the same chain, so
  // PSR always reflects what is actually on the pad.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < S; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_pins_b;
      for (int s = 1; s < S; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign psr = sync_q[S-1];

  // Edge event per pin, polarity chosen by IPR.
  assign edge_evt = (ipr_q & psr & ~prev_q) | (~ipr_q & ~psr & prev_q);

  // ---------------------------------------------------------------------------
  // Register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    pdr_d = pdr_q;
    ddr_d = ddr_q;
    imr_d = imr_q;
    ipr_d = ipr_q;
    isr_d = isr_q;

    if (wr_en) begin
      unique case (addr)
        A_SOPR: pdr_d = pdr_q | wbits;
        A_COPR: pdr_d = pdr_q & ~wbits;
        A_PDR:  pdr_d = (pdr_q & ~wkeep) | wbits;
        A_DDR:  ddr_d = (ddr_q & ~wkeep) | wbits;
        A_PSR:  ;
        A_IMR:  imr_d = (imr_q & ~wkeep) | wbits;
        A_IPR:  ipr_d = (ipr_q & ~wkeep) | wbits;
        A_ISR:  isr_d = isr_q & ~wbits;
        default: ;
      endcase
    end

    // Applied after the W1C so a new event in the same cycle wins.
    isr_d = isr_d | edge_evt;
  end

  // ---------------------------------------------------------------------------
  // Read data: captured on the acknowledging edge of a read, held otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      unique case (addr)
        A_SOPR:  rdata_d = '0;
        A_COPR:  rdata_d = '0;
        A_PDR:   rdata_d = zext(pdr_q);
        A_DDR:   rdata_d = zext(ddr_q);
        A_PSR:   rdata_d = zext(psr);
        A_IMR:   rdata_d = zext(imr_q);
        A_IPR:   rdata_d = zext(ipr_q);
        A_ISR:   rdata_d = zext(isr_q);
        default: rdata_d = '0;
      endcase
    end
  end

  assign irq_d = |(isr_q & imr_q);

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      pdr_q   <= '0;
      ddr_q   <= '0;
      imr_q   <= '0;
      ipr_q   <= '0;
      isr_q   <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      pdr_q   <= pdr_d;
      ddr_q   <= ddr_d;
      imr_q   <= imr_d;
      ipr_q   <= ipr_d;
      isr_q   <= isr_d;
      prev_q  <= psr;
      irq_q   <= irq_d;
    end
  end

  assign wb_ack_o  = ack_q;
  assign wb_data_o = rdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_gpio_port_irq.sv
// -----------------------------------------------------------------------------
// tb_gpio_port_irq
//
// Directed bench for gpio_port_irq. A 32-pin instance is exercised through
// all registers; an 8-pin instance shares the bus to check that bits above
// g_num_pins read 0. Pads are driven per bit from the bench only where the
// DUT is not driving them.
// -----------------------------------------------------------------------------
module tb_gpio_port_irq;

  localparam int S  = 3;
  localparam int S8 = 2;

  // Clock / reset
  logic wb_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 wb_clk = ~wb_clk;

  // Bus
  logic [2:0]  addr  = '0;
  logic [31:0] wdata = '0;
  logic        cyc   = 1'b0;
  logic        stb   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  sel   = '0;
  logic [31:0] dout, dout8;
  logic        ack, ack8, irq, irq8;

  // Pads
  wire  [31:0] pads;
  wire  [7:0]  pads8;
  logic [31:0] tb_en  = 32'hFFFF_FFFF;
  logic [31:0] tb_val = 32'h0;

  for (genvar i = 0; i < 32; i++) begin : g_tb_pad
    assign pads[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_port_irq #(.g_num_pins(32), .g_sync_stages(S)) dut (
    .wb_clk_i   (wb_clk),
    .rst_n_i    (rst_n),
    .wb_addr_i  (addr),
    .wb_data_i  (wdata),
    .wb_data_o  (dout),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_ack_o   (ack),
    .gpio_pins_b(pads),
    .irq_o      (irq)
  );

  gpio_port_irq #(.g_num_pins(8), .g_sync_stages(S8)) dut8 (
    .wb_clk_i   (wb_clk),
    .rst_n_i    (rst_n),
    .wb_addr_i  (addr),
    .wb_data_i  (wdata),
    .wb_data_o  (dout8),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_ack_o   (ack8),
    .gpio_pins_b(pads8),
    .irq_o      (irq8)
  );

  // Scoreboard counters
  int n_total = 0;
  int n_pass  = 0;

  // Values captured on the acknowledging edge of the last bus cycle
  logic        ack_seen;
  logic        irq_at_ack;
  logic [31:0] rd_main;
  logic [31:0] rd8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  // One single-beat transfer: request, ack edge, release, idle edge.
  task automatic bus_cycle(input logic [2:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
    @(posedge wb_clk); #1;
    ack_seen   = ack;
    irq_at_ack = irq;
    rd_main    = dout;
    rd8        = dout8;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge wb_clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus_cycle(a, 1'b1, d, 4'hF);
  endtask

  task automatic rd(input logic [2:0] a);
    bus_cycle(a, 1'b0, 32'h0, 4'hF);
  endtask

  initial begin
    // ---------------- reset state ----------------
    wait_edges(3);
    rst_n = 1'b1;
    wait_edges(1);
    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_data", dout, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check($sformatf("reset_read_%0d", a), rd_main, 32'h0);
      check($sformatf("ack_latency_%0d", a), {31'h0, ack_seen}, 32'h1);
    end

    // Pads undriven by the DUT: the bench's value shows up in PSR.
    tb_val = 32'hA5A5_5A5A;
    wait_edges(S + 1);
    rd(3'd4);
    check("psr_all_inputs", rd_main, 32'hA5A5_5A5A);

    // ---------------- outputs, set/clear ----------------
    tb_en  = 32'h0000_FFFF;
    tb_val = 32'h0000_1234;
    wr(3'd3, 32'hFFFF_0000);
    wr(3'd0, 32'hFF00_FF00);
    wr(3'd1, 32'h5555_5555);
    check("pads_high_driven", {16'h0, pads[31:16]}, 32'h0000_AA00);
    wait_edges(S + 1);
    rd(3'd4);
    check("psr_mixed", rd_main, 32'hAA00_1234);
    rd(3'd2);
    check("pdr_set_clear", rd_main, 32'hAA00_AA00);
    rd(3'd3);
    check("ddr_readback", rd_main, 32'hFFFF_0000);

    // ---------------- external drive on high half ----------------
    tb_en = 32'h0;
    wr(3'd3, 32'h0000_FFFF);
    tb_en  = 32'hFFFF_0000;
    tb_val = 32'hCAFE_0000;
    wait_edges(S + 1);
    rd(3'd4);
    check("psr_cafe", rd_main, 32'hCAFE_AA00);

    // ---------------- interrupts ----------------
    tb_en = 32'hFFFF_0000;
    wr(3'd3, 32'h0);
    tb_en  = 32'hFFFF_FFFF;
    tb_val = 32'h0000_0002;
    wait_edges(6);
    wr(3'd7, 32'hFFFF_FFFF);
    wr(3'd6, 32'h0000_0001);
    wr(3'd5, 32'h0000_0003);
    rd(3'd7);
    check("isr_cleared", rd_main, 32'h0);
    check("irq_idle", {31'h0, irq}, 32'h0);

    // pin0 rising: irq must rise exactly on edge S+2 after the change
    tb_val[0] = 1'b1;
    wait_edges(S + 1);
    check("irq_not_early", {31'h0, irq}, 32'h0);
    wait_edges(1);
    check("irq_on_time", {31'h0, irq}, 32'h1);

    // pin1 falling
    tb_val[1] = 1'b0;
    wait_edges(6);
    rd(3'd7);
    check("isr_both", rd_main, 32'h0000_0003);
    wr(3'd7, 32'h0000_0001);
    rd(3'd7);
    check("isr_after_w1c0", rd_main, 32'h0000_0002);
    check("irq_still_set", {31'h0, irq}, 32'h1);
    wr(3'd7, 32'h0000_0002);
    check("irq_at_last_clear", {31'h0, irq_at_ack}, 32'h1);
    check("irq_falls", {31'h0, irq}, 32'h0);

    // pin2 event while masked (falling edge, IPR[2]=0)
    tb_val[2] = 1'b1;
    wait_edges(5);
    tb_val[2] = 1'b0;
    wait_edges(6);
    rd(3'd7);
    check("isr_masked_event", rd_main, 32'h0000_0004);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(3'd5, 32'h0000_0004);
    check("irq_at_imr_ack", {31'h0, irq_at_ack}, 32'h0);
    check("irq_after_unmask", {31'h0, irq}, 32'h1);

    // ---------------- W1C collision on pin0 ----------------
    tb_val[0] = 1'b0;
    wait_edges(6);
    tb_val[0] = 1'b1;
    wait_edges(6);
    tb_val[0] = 1'b0;
    wait_edges(6);
    rd(3'd7);
    check("isr_before_collision", rd_main, 32'h0000_0005);
    tb_val[0] = 1'b1;
    wait_edges(S);
    wr(3'd7, 32'h0000_0001);
    rd(3'd7);
    check("isr_collision_set_wins", rd_main, 32'h0000_0005);

    // ---------------- byte lanes ----------------
    wr(3'd2, 32'h0);
    bus_cycle(3'd2, 1'b1, 32'h1234_5678, 4'b0101);
    rd(3'd2);
    check("pdr_byte_lanes", rd_main, 32'h0034_0078);

    // ---------------- narrow instance ----------------
    tb_en = 32'h0;
    wr(3'd3, 32'hFFFF_FFFF);
    rd(3'd3);
    check("ddr8_width", rd8, 32'h0000_00FF);
    check("ddr32_width", rd_main, 32'hFFFF_FFFF);
    check("pads_all_driven", pads, 32'h0034_0078);
    rd(3'd2);
    check("pdr8_width", rd8, 32'h0000_0078);

    // ---------------- held strobe and reset mid-transfer ----------------
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 3'd3; sel = 4'hF;
    wait_edges(1);
    check("held_ack_1", {31'h0, ack}, 32'h1);
    wait_edges(1);
    check("held_ack_2", {31'h0, ack}, 32'h0);
    wait_edges(1);
    check("held_ack_3", {31'h0, ack}, 32'h1);
    check("irq_before_reset", {31'h0, irq}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_ack", {31'h0, ack}, 32'h0);
    check("reset_clears_irq", {31'h0, irq}, 32'h0);
    check("reset_clears_data", dout, 32'h0);
    cyc = 1'b0; stb = 1'b0;
    tb_en = 32'hFFFF_FFFF;
    tb_val = 32'h0;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(1);
    rd(3'd3);
    check("ddr_after_reset", rd_main, 32'h0);
    rd(3'd7);
    check("isr_after_reset", rd_main, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
